// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit async SRAM as two half-word transfers.
// Optional define SRAM_ADDR_CHECK_EN adds range checking and the addr_err output.
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        ST_val,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_out,
  input  logic [15:0]        SRAM_DQ_in,
  output logic               SRAM_DQ_oe,
  output logic               SRAM_WE_N
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic               addr_err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] WC_LAST = 3'(WAIT_STATES);

  logic [1:0]         r_state;
  logic [2:0]         r_wc;
  logic               r_is_wr;
  logic [SRAM_AW-2:0] r_word;
  logic [31:0]        r_st_val;
  logic [31:0]        r_read_data;
  logic [SRAM_AW-1:0] r_sram_addr;

  logic               w_req;
  logic [31:0]        w_offset;
  logic [SRAM_AW-2:0] w_word;
  logic               w_oor;
  logic               w_wr_active;

  assign w_req    = MEM_R_EN | MEM_W_EN;
  assign w_offset = address - BASE_ADDR;
  // Truncation to SRAM_AW-1 bits gives the modulo-SRAM-size wrap of the word index.
  assign w_word   = (SRAM_AW-1)'(w_offset >> 2);

`ifdef SRAM_ADDR_CHECK_EN
  logic r_addr_err;
  assign w_oor    = (address < BASE_ADDR) || ((w_offset >> (SRAM_AW + 1)) != 32'd0);
  assign addr_err = r_addr_err;
`else
  assign w_oor    = 1'b0;
`endif

  assign w_wr_active = r_is_wr && ((r_state == S_LOW) || (r_state == S_HIGH));

  always_comb begin
    SRAM_WE_N   = ~w_wr_active;
    SRAM_DQ_oe  = w_wr_active;
    SRAM_DQ_out = 16'h0000;
    if (w_wr_active) begin
      SRAM_DQ_out = (r_state == S_HIGH) ? r_st_val[31:16] : r_st_val[15:0];
    end
  end

  assign ready     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
  assign read_data = r_read_data;
  assign SRAM_ADDR = r_sram_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wc        <= 3'd0;
      r_is_wr     <= 1'b0;
      r_word      <= '0;
      r_st_val    <= 32'd0;
      r_read_data <= 32'd0;
      r_sram_addr <= '0;
`ifdef SRAM_ADDR_CHECK_EN
      r_addr_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_is_wr  <= MEM_W_EN;
            r_word   <= w_word;
            r_st_val <= ST_val;
            r_wc     <= 3'd0;
            if (w_oor) begin
              // Rejected access: skip the SRAM entirely and complete next cycle.
              r_state <= S_DONE;
              if (!MEM_W_EN) r_read_data <= 32'd0;
`ifdef SRAM_ADDR_CHECK_EN
              r_addr_err <= 1'b1;
`endif
            end else begin
              r_state     <= S_LOW;
              r_sram_addr <= {w_word, 1'b0};
            end
          end
        end
        S_LOW: begin
          if (r_wc == WC_LAST) begin
            r_wc        <= 3'd0;
            r_state     <= S_HIGH;
            r_sram_addr <= {r_word, 1'b1};
            if (!r_is_wr) r_read_data[15:0] <= SRAM_DQ_in;
          end else begin
            r_wc <= r_wc + 3'd1;
          end
        end
        S_HIGH: begin
          if (r_wc == WC_LAST) begin
            r_wc    <= 3'd0;
            r_state <= S_DONE;
            if (!r_is_wr) r_read_data[31:16] <= SRAM_DQ_in;
          end else begin
            r_wc <= r_wc + 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
`ifdef SRAM_ADDR_CHECK_EN
          r_addr_err <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule
